dp_controller: RTL

Sequencing controller for ARM data-processing instructions. It is the initiator side of the registered ALU/shifter datapath. It accepts one 32-bit instruction word, decodes it, and drives register-file read addresses. It then issues SHIFT_OP/Shift_Num/ALU_OP/LF/S to the datapath for one execute cycle and writes the registered result F back to the register file. The condition field is evaluated against the datapath's NZCV flags before any state-changing strobe is raised.

---
 rtl/dp_controller.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/dp_controller.sv
// Sequencing controller for ARM data-processing instructions.
// Ports: clk, Rst (async, active-high); Inst_Valid/Inst/Inst_Ready instruction
// handshake; NZCV flags and R_Data_C (Rs data) from the datapath;
// R_Addr_A/B/C register reads; Imm_Sel, Imm32, SHIFT_OP, Shift_Num, ALU_OP,
// LF, S datapath controls; W_Addr/Write_Reg write-back; Done, Cond_Fail,
// Undef status pulses. Define DP_CTRL_COND_EN to evaluate the condition
// field; otherwise every defined instruction executes as AL.
module dp_controller (
  input  logic        clk,
  input  logic        Rst,
  input  logic        Inst_Valid,
  input  logic [31:0] Inst,
  output logic        Inst_Ready,
  input  logic [3:0]  NZCV,
  input  logic [31:0] R_Data_C,
  output logic [3:0]  R_Addr_A,
  output logic [3:0]  R_Addr_B,
  output logic [3:0]  R_Addr_C,
  output logic        Imm_Sel,
  output logic [31:0] Imm32,
  output logic [2:0]  SHIFT_OP,
  output logic [7:0]  Shift_Num,
  output logic [3:0]  ALU_OP,
  output logic        LF,
  output logic        S,
  output logic [3:0]  W_Addr,
  output logic        Write_Reg,
  output logic        Done,
  output logic        Cond_Fail,
  output logic        Undef
);

  typedef enum logic [1:0] {
    IDLE, FETCH, EXEC, WB
  } state_t;

  state_t      state, state_nx;
  logic [31:0] ir;
  logic [7:0]  cnt;
  logic        squash;
  logic        undef;
  logic        shreg;
  logic        cond_pass;
  logic        exec_ok;
  logic        unused_ok;

  assign undef = (ir[27:26] != 2'b00)
               | (~ir[25] & ir[7] & ir[4]);
  assign shreg = ~ir[25] & ir[4];
  assign exec_ok = cond_pass & ~undef;

`ifdef DP_CTRL_COND_EN
  logic n, z, c, v;
  assign {n, z, c, v} = NZCV;

  always_comb begin
    cond_pass = 1'b0;
    unique case (ir[31:28])
      4'h0: cond_pass = z;
      4'h1: cond_pass = ~z;
      4'h2: cond_pass = c;
      4'h3: cond_pass = ~c;
      4'h4: cond_pass = n;
      4'h5: cond_pass = ~n;
      4'h6: cond_pass = v;
      4'h7: cond_pass = ~v;
      4'h8: cond_pass = c & ~z;
      4'h9: cond_pass = ~c | z;
      4'hA: cond_pass = (n == v);
      4'hB: cond_pass = (n != v);
      4'hC: cond_pass = ~z & (n == v);
      4'hD: cond_pass = z | (n != v);
      4'hE: cond_pass = 1'b1;
      4'hF: cond_pass = 1'b0;
    endcase
  end

  assign unused_ok = ^R_Data_C[31:8];
`else
  assign cond_pass = 1'b1;
  assign unused_ok = ^{NZCV, R_Data_C[31:8]};
`endif

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state  <= IDLE;
      ir     <= '0;
      cnt    <= '0;
      squash <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && Inst_Valid)
        ir <= Inst;
      if (state == FETCH && shreg)
        cnt <= R_Data_C[7:0];
      if (state == EXEC)
        squash <= ~exec_ok;
    end
  end

  always_comb begin
    state_nx   = state;
    Inst_Ready = 1'b0;
    LF         = 1'b0;
    S          = 1'b0;
    Write_Reg  = 1'b0;
    Done       = 1'b0;
    Cond_Fail  = 1'b0;
    Undef      = 1'b0;
    unique case (state)
      IDLE: begin
        Inst_Ready = ~Rst;
        if (Inst_Valid)
          state_nx = FETCH;
      end
      FETCH: state_nx = EXEC;
      EXEC: begin
        state_nx = WB;
        LF = exec_ok;
        S  = exec_ok & ir[20];
      end
      WB: begin
        state_nx  = IDLE;
        Done      = 1'b1;
        Undef     = undef;
        // compare/test opcodes only touch flags
        Write_Reg = ~squash & (ir[24:23] != 2'b10);
`ifdef DP_CTRL_COND_EN
        Cond_Fail = squash;
`endif
      end
    endcase
  end

  assign R_Addr_A = ir[19:16];
  assign R_Addr_B = ir[3:0];
  assign R_Addr_C = ir[11:8];
  assign W_Addr   = ir[15:12];
  assign ALU_OP   = ir[24:21];
  assign Imm_Sel  = ir[25];
  assign Imm32    = {24'b0, ir[7:0]};

  always_comb begin
    SHIFT_OP  = {ir[6:5], ir[4]};
    Shift_Num = {3'b0, ir[11:7]};
    if (ir[25]) begin
      SHIFT_OP  = 3'b110;
      Shift_Num = {3'b0, ir[11:8], 1'b0};
    end else if (shreg) begin
      // Rs data is live during FETCH, latched count afterwards
      Shift_Num = (state == FETCH) ? R_Data_C[7:0] : cnt;
    end
  end

endmodule
